// File: rtl/instr_encode_loader.sv
// instr_encode_loader: encodes MIPS instruction tuples and writes them sequentially into IMEM
module instr_encode_loader #(
  parameter int ADDR_W = 6,
  parameter int DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              InValid,
  output logic              InReady,
  input  logic [4:0]        OpSel,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic [4:0]        Shamt,
  input  logic [15:0]       Imm,
  input  logic              Last,
  output logic              ImemWE,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [31:0]       ImemData,
  output logic [ADDR_W:0]   Count,
  output logic              Done,
  output logic              Full
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t              r_state;
  logic                r_we, r_done, r_full;
  logic [ADDR_W-1:0]   r_addr, r_ptr;
  logic [31:0]         r_data;
  logic [ADDR_W:0]     r_count;
  logic [5:0]          w_code;
  logic                w_shift, w_muldiv, w_zrt, w_acc, w_cap;
  logic [31:0]         w_enc;
  assign InReady  = r_state == LOAD;
  assign w_acc    = InValid & InReady;
  assign w_cap    = r_count == (ADDR_W+1)'(DEPTH - 1);
  assign ImemWE   = r_we;
  assign ImemAddr = r_addr;
  assign ImemData = r_data;
  assign Count    = r_count;
  assign Done     = r_done;
  assign Full     = r_full;
  // funct for R-type (OpSel < 19), primary opcode for I-type
  always_comb begin
    w_code = 6'b000000;
    case (OpSel)
      5'd0:    w_code = 6'b100001;
      5'd1:    w_code = 6'b100011;
      5'd2:    w_code = 6'b100100;
      5'd3:    w_code = 6'b100101;
      5'd4:    w_code = 6'b101010;
      5'd5:    w_code = 6'b101011;
      5'd6:    w_code = 6'b100110;
      5'd7:    w_code = 6'b000000;
      5'd8:    w_code = 6'b000010;
      5'd9:    w_code = 6'b000011;
      5'd10:   w_code = 6'b000100;
      5'd11:   w_code = 6'b000110;
      5'd12:   w_code = 6'b000111;
      5'd13:   w_code = 6'b100000;
      5'd14:   w_code = 6'b100010;
      5'd15:   w_code = 6'b011010;
      5'd16:   w_code = 6'b011011;
      5'd17:   w_code = 6'b011000;
      5'd18:   w_code = 6'b011001;
      5'd19:   w_code = 6'b001001;
      5'd20:   w_code = 6'b001000;
      5'd21:   w_code = 6'b001100;
      5'd22:   w_code = 6'b001101;
      5'd23:   w_code = 6'b001010;
      5'd24:   w_code = 6'b001011;
      5'd25:   w_code = 6'b001110;
      5'd26:   w_code = 6'b100011;
      5'd27:   w_code = 6'b101011;
      5'd28:   w_code = 6'b000100;
      5'd29:   w_code = 6'b000101;
      5'd30:   w_code = 6'b000111;
      default: w_code = 6'b000110;
    endcase
  end
  assign w_shift  = OpSel >= 5'd7 && OpSel <= 5'd9;
  assign w_muldiv = OpSel >= 5'd15 && OpSel <= 5'd18;
  assign w_zrt    = OpSel >= 5'd30;
  assign w_enc = OpSel < 5'd19
    ? {6'b0, w_shift ? 5'd0 : Rs, Rt, w_muldiv ? 5'd0 : Rd, w_shift ? Shamt : 5'd0, w_code}
    : {w_code, Rs, w_zrt ? 5'd0 : Rt, Imm};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_full  <= 1'b0;
      r_ptr   <= '0;
    end else begin
      r_we <= w_acc;
      if (w_acc) begin
        r_addr  <= r_ptr;
        r_data  <= w_enc;
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count + 1'b1;
        if (Last || w_cap) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          r_full  <= w_cap;
        end
      end else if (Start && r_state != LOAD) begin
        r_state <= LOAD;
        r_count <= '0;
        r_done  <= 1'b0;
        r_full  <= 1'b0;
        r_ptr   <= BaseAddr;
      end
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed and random stimulus against a cycle-level reference model
module tb_instr_encode_loader;
  localparam int ADDR_W = 6;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 1, Start = 0, InValid = 0, Last = 0;
  logic [ADDR_W-1:0] BaseAddr = 0;
  logic [4:0] OpSel = 0, Rs = 0, Rt = 0, Rd = 0, Shamt = 0;
  logic [15:0] Imm = 0;
  logic InReady, ImemWE, Done, Full;
  logic [ADDR_W-1:0] ImemAddr;
  logic [31:0] ImemData;
  logic [ADDR_W:0] Count;
  int checks = 0, failures = 0;
  bit m_load, m_we, m_done, m_full;
  int m_ptr, m_count, m_addr;
  logic [31:0] m_data;
  int rfn[19] = '{33, 35, 36, 37, 42, 43, 38, 0, 2, 3, 4, 6, 7, 32, 34, 26, 27, 24, 25};
  int iop[13] = '{9, 8, 12, 13, 10, 11, 14, 35, 43, 4, 5, 7, 6};

  instr_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Start(Start), .BaseAddr(BaseAddr), .InValid(InValid),
    .InReady(InReady), .OpSel(OpSel), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm),
    .Last(Last), .ImemWE(ImemWE), .ImemAddr(ImemAddr), .ImemData(ImemData), .Count(Count),
    .Done(Done), .Full(Full));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rs, input int rt, input int rd,
                                      input int sh, input int imm);
    int word;
    if (op < 19) begin
      if (op >= 7 && op <= 9) rs = 0; else sh = 0;
      if (op >= 15) begin rd = 0; sh = 0; end
      word = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + rfn[op];
    end else begin
      if (op >= 30) rt = 0;
      word = iop[op-19] * 67108864 + rs * 2097152 + rt * 65536 + imm;
    end
    return 32'(word);
  endfunction

  // One clock: drive inputs, check InReady before the edge, advance model, check outputs after
  task automatic cyc(input bit rst, input bit st, input int base, input bit v, input int op,
                     input int rs, input int rt, input int rd, input int sh, input int imm,
                     input bit last);
    reset = rst; Start = st; BaseAddr = ADDR_W'(base); InValid = v; OpSel = 5'(op);
    Rs = 5'(rs); Rt = 5'(rt); Rd = 5'(rd); Shamt = 5'(sh); Imm = 16'(imm); Last = last;
    #2;
    chk("InReady", 32'(InReady), 32'(m_load && !rst ? 1 : (m_load ? 1 : 0)));
    @(posedge clk);
    if (rst) begin
      m_load = 0; m_we = 0; m_addr = 0; m_data = 0; m_count = 0; m_done = 0; m_full = 0; m_ptr = 0;
    end else begin
      m_we = v && m_load;
      if (m_we) begin
        m_addr = m_ptr; m_data = enc(op, rs, rt, rd, sh, imm);
        m_ptr = (m_ptr + 1) % (1 << ADDR_W); m_count++;
        if (last || m_count == DEPTH) begin m_load = 0; m_done = 1; m_full = m_count == DEPTH; end
      end else if (st && !m_load) begin
        m_load = 1; m_count = 0; m_done = 0; m_full = 0; m_ptr = base;
      end
    end
    #1;
    chk("ImemWE", 32'(ImemWE), 32'(m_we));
    chk("ImemAddr", 32'(ImemAddr), 32'(m_addr));
    chk("ImemData", ImemData, m_data);
    chk("Count", 32'(Count), 32'(m_count));
    chk("Done", 32'(Done), 32'(m_done));
    chk("Full", 32'(Full), 32'(m_full));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_load = 0; m_we = 0; m_addr = 0; m_data = 0; m_count = 0; m_done = 0; m_full = 0; m_ptr = 0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 1, 3, 1, 1, 1, 1, 1, 0);
    chk("reset_we", 32'(ImemWE), 0);
    chk("reset_ready", 32'(InReady), 0);
    // addu with a stray Shamt, ending the session
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("start_ready", 32'(InReady), 1);
    cyc(0, 0, 0, 1, 0, 1, 2, 3, 7, 0, 1);
    chk("addu_data", ImemData, 32'h00221821);
    chk("addu_addr", 32'(ImemAddr), 0);
    chk("addu_done", 32'(Done), 1);
    // lw, sll, Start ignored mid-session, then bgtz as Last
    cyc(0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 26, 29, 8, 0, 0, 4, 0);
    chk("lw_data", ImemData, 32'h8FA80004);
    cyc(0, 0, 0, 1, 7, 5, 3, 2, 4, 0, 0);
    chk("sll_data", ImemData, 32'h00031100);
    chk("sll_addr", 32'(ImemAddr), 11);
    cyc(0, 1, 40, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 30, 4, 9, 0, 0, 16'hFFFE, 1);
    chk("bgtz_data", ImemData, 32'h1C80FFFE);
    chk("bgtz_addr", 32'(ImemAddr), 12);
    chk("bgtz_done", 32'(Done), 1);
    chk("bgtz_full", 32'(Full), 0);
    idle();
    chk("done_ready", 32'(InReady), 0);
    // five back-to-back valids fill DEPTH words
    cyc(0, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 19 + i, i, i + 1, 0, 0, i * 3, 0);
    chk("depth_count", 32'(Count), DEPTH);
    chk("depth_full", 32'(Full), 1);
    chk("depth_addr", 32'(ImemAddr), 23);
    // pointer wrap with a gap
    cyc(0, 1, 63, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 13, 1, 2, 3, 0, 0, 0);
    chk("wrap_addr0", 32'(ImemAddr), 63);
    cyc(0, 0, 0, 0, 14, 1, 2, 3, 0, 0, 0);
    chk("gap_we", 32'(ImemWE), 0);
    cyc(0, 0, 0, 1, 15, 4, 5, 6, 7, 0, 0);
    chk("wrap_addr1", 32'(ImemAddr), 0);
    // reset the cycle after an accept drops the write
    cyc(0, 0, 0, 1, 22, 1, 1, 0, 0, 16'h1234, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mid_we", 32'(ImemWE), 0);
    chk("rst_mid_data", ImemData, 0);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, int'($urandom_range(0, 63)),
          $urandom_range(0, 2) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 65535)), $urandom_range(0, 4) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
